// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the issuing stage and mul_div_unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            dbz;

    modport master (output start, op, opA, opB, input busy, done, hi, lo, dbz);
    modport slave  (input start, op, opA, opB, output busy, done, hi, lo, dbz);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit (one bit per cycle, sign fix-up at the end).
// The restoring divider is built only when MUL_DIV_DIVIDER_EN is defined.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo} product, or {remainder, quotient}
    logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic              flag_q, flag_d;
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic              done_q, done_d, dbz_q, dbz_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, div_next, fix_prod, fix_acc;
    logic [XLEN-1:0]   fix_hi, fix_lo;

    assign a_neg = ~bus.op[0] & bus.opA[XLEN-1];
    assign b_neg = ~bus.op[0] & bus.opB[XLEN-1];
    assign mag_a = a_neg ? -bus.opA : bus.opA;
    assign mag_b = b_neg ? -bus.opB : bus.opB;

    // Multiplier lives in the low half and is shifted out as product bits shift in.
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

`ifdef MUL_DIV_DIVIDER_EN
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;

    // Shifted remainder needs XLEN+1 bits once the divisor exceeds 2^(XLEN-1).
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign diff     = {1'b0, rem_sh} - {2'b00, opnd_q};
    assign div_next = {diff[XLEN+1] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0],
                       acc_q[XLEN-2:0], ~diff[XLEN+1]};
`else
    assign div_next = acc_q;
`endif

    assign fix_prod = neg_res_q ? -acc_q : acc_q;
    assign fix_hi   = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign fix_lo   = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign fix_acc  = is_div_q ? {fix_hi, fix_lo} : fix_prod;

    // NOTE: non-blocking assignments make every flop sample pre-edge values, so order is irrelevant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // NOTE: the default at the top covers every path, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (!bus.op[1]) begin
                        state_d = MUL;
                    end else begin
`ifdef MUL_DIV_DIVIDER_EN
                        state_d = (bus.opB == '0) ? FIX : DIV;
`else
                        state_d = FIX;
`endif
                    end
                end
            end
            MUL:     if (cnt_q == 5'd31) state_d = FIX;
            DIV:     if (cnt_q == 5'd31) state_d = FIX;
            FIX:     if (cnt_q[0]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
        bus.done = done_q;
        bus.hi   = hi_q;
        bus.lo   = lo_q;
        bus.dbz  = dbz_q;
    end

    // FIX spends two cycles: cnt_q[0]=0 applies signs, cnt_q[0]=1 publishes the result.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        flag_d    = flag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d     = '0;
                    acc_d     = {{XLEN{1'b0}}, mag_a};
                    opnd_d    = mag_b;
                    is_div_d  = bus.op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg & bus.op[1];
                    flag_d    = 1'b0;
                    if (bus.op[1]) begin
`ifdef MUL_DIV_DIVIDER_EN
                        if (bus.opB == '0) begin
                            acc_d     = {bus.opA, {XLEN{1'b1}}};
                            neg_res_d = 1'b0;
                            neg_rem_d = 1'b0;
                            flag_d    = 1'b1;
                        end
`else
                        // Unsupported op: republish the current hi/lo with dbz set.
                        acc_d     = {hi_q, lo_q};
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                        flag_d    = 1'b1;
                        cnt_d     = 5'd1;
`endif
                    end
                end
            end
            MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 5'd1;
            end
            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 5'd1;
            end
            FIX: begin
                if (!cnt_q[0]) begin
                    acc_d = fix_acc;
                    cnt_d = 5'd1;
                end else begin
                    hi_d   = acc_q[2*XLEN-1:XLEN];
                    lo_d   = acc_q[XLEN-1:0];
                    done_d = 1'b1;
                    dbz_d  = flag_q;
                    cnt_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: datapath flops are reset as well, so no X can ever reach hi/lo or the sign logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            flag_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            flag_q    <= flag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled on rising clk edges only.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port opA  input  32  first operand (multiplicand or dividend), driven from the register-file DataRead1 output.
REQ-007 SHALL have port opB  input  32  second operand (multiplier or divisor), driven from the register-file DataRead2 output.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking that hi and lo hold a new result.
REQ-010 SHALL have port hi  output  32  product upper word or remainder.
REQ-011 SHALL have port lo  output  32  product lower word or quotient.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, FIX.
REQ-014 SHALL, in IDLE with start=1, capture op, opA and opB on the edge and go to MUL (op[1]=0) or DIV (op[1]=1); start SHALL be ignored in every non-IDLE state.
REQ-015 SHALL, at capture, convert signed operands (MULT, DIV) to magnitudes and record the result sign(s).
REQ-016 SHALL, in MUL, perform one shift-add step per cycle for exactly 32 cycles, counted by a 5-bit counter, then go to FIX.
REQ-017 SHALL, in DIV, perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-018 SHALL, in FIX, negate the 64-bit product when its operand signs differ (MULT only), negate the quotient when the signs differ, and negate the remainder when the dividend is negative (DIV only); FIX SHALL then load hi/lo, pulse done, and return to IDLE.
REQ-019 SHALL update hi, lo and done on the 34th rising edge after the capture edge.
REQ-020 SHALL hold busy=1 from the capture edge until that 34th edge, so busy falls on the same edge on which done rises.
REQ-021 SHALL drive done high for exactly one cycle per operation.
REQ-022 SHALL hold hi and lo stable at all other times.
REQ-023 SHALL handle a DIV or DIVU capture with opB=0 by going straight to FIX, then producing hi=opA, lo=32'hFFFFFFFF and dbz=1, with done on the 2nd edge after capture.
REQ-024 SHALL clear dbz at every non-zero-divisor completion.
REQ-025 SHALL produce DIV 0x80000000 / 0xFFFFFFFF as lo=0x80000000, hi=0, dbz=0, with no trap.
REQ-026 SHALL accept start on the edge after done, with no required idle cycle.

Reset
REQ-027 SHALL, while rst=0, force state=IDLE, counter=0, busy=0, done=0, dbz=0, hi=0 and lo=0, independent of clk.
REQ-028 SHALL abandon any in-flight operation when rst is asserted mid-operation and produce no done after release.
REQ-029 SHALL, on the first edge after rst returns high, accept start normally.

Configuration
REQ-030 SHALL compile the divider datapath only when macro MUL_DIV_DIVIDER_EN is defined; with the macro, op 10 and 11 SHALL behave per REQ-017 to REQ-025.
REQ-031 SHALL, without MUL_DIV_DIVIDER_EN, complete op 10 and 11 with done on the 1st edge after capture, leave hi and lo unchanged, and set dbz=1 as the unsupported-operation indication, with multiply behaviour unaffected.

Verification
REQ-032 SHALL cover: MULT opA=7, opB=0xFFFFFFFD -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, done on the 34th edge, busy high for 34 cycles.
REQ-033 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 SHALL cover: DIV opA=0xFFFFFFF9 (-7), opB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dbz=0; DIVU 100/7 -> lo=14, hi=2.
REQ-035 SHALL cover: DIVU opA=100, opB=0 -> hi=100, lo=0xFFFFFFFF, dbz=1, done on the 2nd edge.
REQ-036 SHALL cover: start re-pulsed with different operands at cycle 10 of a MULT -> ignored, and the first result is unchanged.
REQ-037 SHALL cover: rst=0 at cycle 15 of a DIV -> busy=0 and hi=lo=0 immediately, with no done afterward; a new MULT 3x5 then gives lo=15.
